// File: rtl/serial_frame_rx.sv
// serial_frame_rx: single-line serial receiver. Finds a start bit, samples
// WIDTH data bits LSB-first at mid-bit, checks the stop bit and strobes the
// assembled word (data_valid) or a framing error (frame_err).
module serial_frame_rx #(
  parameter int WIDTH      = 8,
  parameter int BIT_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             frame_err,
  output logic             busy
);
  localparam int HALF = BIT_CYCLES / 2;
  localparam int CW   = $clog2(BIT_CYCLES + 1);
  localparam int IW   = $clog2(WIDTH + 1);
  // START counts to the mid-point of the start bit; every later bit is a
  // full bit period measured from the previous mid-point sample.
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(WIDTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] shreg;
  logic             cnt_hit, cnt_run, take_bit, good, bad;

  // Next-state decode plus per-edge control strobes for the datapath.
  always_comb begin
    state_nxt = state;
    cnt_run   = 1'b0;
    take_bit  = 1'b0;
    good      = 1'b0;
    bad       = 1'b0;
    cnt_hit   = (state == S_START) ? (cnt == HALF_LAST) : (cnt == BIT_LAST);
    case (state)
      S_IDLE:  if (!data_in) state_nxt = S_START;
      S_START: begin
        cnt_run = !cnt_hit;
        // a start bit that has gone high by mid-bit was only a glitch
        if (cnt_hit) state_nxt = data_in ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        cnt_run = !cnt_hit;
        if (cnt_hit) begin
          take_bit = 1'b1;
          if (idx == IDX_LAST) state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        cnt_run = !cnt_hit;
        if (cnt_hit) begin
          good      = data_in;
          bad       = !data_in;
          state_nxt = data_in ? S_IDLE : S_BREAK;
        end
      end
      // line held low after a bad stop bit: wait for it to return high
      S_BREAK: if (data_in) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      idx        <= '0;
      shreg      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_run ? cnt + 1'b1 : '0;
      data_valid <= good;
      frame_err  <= bad;
      busy       <= (state_nxt != S_IDLE);
      if (good) data_out <= shreg;
      if (state == S_START)  idx <= '0;
      else if (take_bit)     idx <= idx + 1'b1;
      if (take_bit) begin
        for (int i = 0; i < WIDTH; i++)
          if (idx == IW'(i)) shreg[i] <= data_in;
      end
    end
  end
endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: builds per-edge line/reset traces, predicts the
// outputs with a frame-level model (absolute sample times from E0) and
// compares every edge.
module tb_serial_frame_rx;
  localparam int W    = 8;
  localparam int B    = 4;
  localparam int HALF = B / 2;
  localparam int LAT  = HALF + (W + 1) * B;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         data_in = 1'b1;
  logic [W-1:0] data_out;
  logic         data_valid, frame_err, busy;

  serial_frame_rx #(.WIDTH(W), .BIT_CYCLES(B)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in),
    .data_out(data_out), .data_valid(data_valid),
    .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  bit           lq[$];               // line level applied at each edge
  bit           rq[$];               // reset asserted at each edge
  logic [W-1:0] m_dout = '0;         // data_out expected before the trace
  logic         o_v[$], o_e[$], o_b[$];
  logic [W-1:0] o_d[$];
  logic         e_v[$], e_e[$], e_b[$];
  logic [W-1:0] e_d[$];

  task automatic add_level(bit v, int n);
    repeat (n) begin lq.push_back(v); rq.push_back(1'b0); end
  endtask

  task automatic add_frame(logic [W-1:0] w, bit stop, bit noise);
    add_level(1'b0, B);
    for (int k = 0; k < W; k++)
      for (int c = 0; c < B; c++) begin
        lq.push_back((noise && c != HALF) ? ($urandom_range(0, 1) != 0) : w[k]);
        rq.push_back(1'b0);
      end
    add_level(stop, B);
  endtask

  function automatic bit ln(int i);
    return (i < lq.size()) ? lq[i] : 1'b1;
  endfunction

  function automatic int first_rst(int a, int b);
    for (int i = a; i <= b && i < rq.size(); i++) if (rq[i]) return i;
    return -1;
  endfunction

  // Frame-level reference: locate E0, decide glitch / good / bad from the
  // line at the fixed sample offsets, then paint expected outputs per edge.
  task automatic model();
    int n, t, e0, es, fin, r;
    bit glitch;
    logic [W-1:0] dout, word;
    n = lq.size();
    e_v.delete(); e_e.delete(); e_b.delete(); e_d.delete();
    for (int i = 0; i < n; i++) begin
      e_v.push_back(1'b0); e_e.push_back(1'b0); e_b.push_back(1'b0); e_d.push_back('0);
    end
    dout = m_dout;
    t = 0;
    while (t < n) begin
      if (rq[t]) begin dout = '0; e_d[t] = '0; t++; continue; end
      if (lq[t]) begin e_d[t] = dout; t++; continue; end
      e0 = t;
      es = e0 + LAT;
      glitch = ln(e0 + HALF);
      if (glitch)       fin = e0 + HALF;
      else if (ln(es))  fin = es;
      else begin fin = es + 1; while (!ln(fin)) fin++; end
      r = first_rst(e0, fin);
      if (r >= 0) begin
        for (int i = e0; i < r; i++) begin e_b[i] = 1'b1; e_d[i] = dout; end
        t = r;
        continue;
      end
      for (int i = e0; i <= fin && i < n; i++) begin e_b[i] = (i != fin); e_d[i] = dout; end
      if (!glitch) begin
        for (int k = 0; k < W; k++) word[k] = ln(e0 + HALF + (k + 1) * B);
        if (es < n) begin
          if (ln(es)) begin e_v[es] = 1'b1; dout = word; e_d[es] = word; end
          else        e_e[es] = 1'b1;
        end
      end
      t = fin + 1;
    end
    m_dout = dout;
  endtask

  // Apply the trace (inputs at negedge) and record outputs 1ns after each edge.
  task automatic run();
    model();
    o_v.delete(); o_e.delete(); o_b.delete(); o_d.delete();
    for (int i = 0; i < lq.size(); i++) begin
      @(negedge clk);
      data_in = lq[i];
      rst_n   = !rq[i];
      @(posedge clk);
      #1;
      o_v.push_back(data_valid); o_e.push_back(frame_err);
      o_b.push_back(busy);       o_d.push_back(data_out);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); rst_n = 1'b0; data_in = i[0];
      @(posedge clk); #1;
      vectors++;
      if ({data_valid, frame_err, busy, data_out} !== '0) begin
        miscompares++;
        $display("FAIL reset_hold edge %0d: got v=%b e=%b busy=%b dout=%h, want all 0",
                 i, data_valid, frame_err, busy, data_out);
      end
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); rst_n = 1'b1; data_in = 1'b1;
      @(posedge clk); #1;
      vectors++;
      if ({data_valid, frame_err, busy, data_out} !== '0) begin
        miscompares++;
        $display("FAIL reset_release edge %0d: got v=%b e=%b busy=%b dout=%h, want all 0",
                 i, data_valid, frame_err, busy, data_out);
      end
    end
    m_dout = '0;
  endtask

  task automatic test_good_frame();
    lq.delete(); rq.delete();
    add_level(1'b1, 3); add_frame(8'hA5, 1'b1, 1'b0); add_level(1'b1, 4);
    run();
    for (int i = 0; i < o_v.size(); i++) begin
      vectors++;
      if ({o_v[i], o_e[i], o_b[i], o_d[i]} !== {e_v[i], e_e[i], e_b[i], e_d[i]}) begin
        miscompares++;
        $display("FAIL good_frame edge %0d: got v=%b e=%b b=%b d=%h, want v=%b e=%b b=%b d=%h",
                 i, o_v[i], o_e[i], o_b[i], o_d[i], e_v[i], e_e[i], e_b[i], e_d[i]);
      end
    end
    vectors++;
    if (o_v[3+LAT] !== 1'b1 || o_d[3+LAT] !== 8'hA5 || o_v[4+LAT] !== 1'b0 || o_b[3+LAT] !== 1'b0) begin
      miscompares++;
      $display("FAIL good_frame_latency: got v=%b d=%h next_v=%b busy=%b, want v=1 d=a5 next_v=0 busy=0",
               o_v[3+LAT], o_d[3+LAT], o_v[4+LAT], o_b[3+LAT]);
    end
  endtask

  task automatic test_glitch();
    lq.delete(); rq.delete();
    add_level(1'b1, 3); add_level(1'b0, 1); add_level(1'b1, 6);
    run();
    for (int i = 0; i < o_v.size(); i++) begin
      vectors++;
      if ({o_v[i], o_e[i], o_b[i], o_d[i]} !== {e_v[i], e_e[i], e_b[i], e_d[i]}) begin
        miscompares++;
        $display("FAIL glitch edge %0d: got v=%b e=%b b=%b d=%h, want v=%b e=%b b=%b d=%h",
                 i, o_v[i], o_e[i], o_b[i], o_d[i], e_v[i], e_e[i], e_b[i], e_d[i]);
      end
    end
    vectors++;
    if ({o_b[2], o_b[3], o_b[4], o_b[5]} !== 4'b0110 || o_d[8] !== 8'hA5) begin
      miscompares++;
      $display("FAIL glitch_busy: got busy=%b%b%b%b d=%h, want busy=0110 d=a5",
               o_b[2], o_b[3], o_b[4], o_b[5], o_d[8]);
    end
  endtask

  task automatic test_frame_err();
    lq.delete(); rq.delete();
    add_level(1'b1, 2); add_frame(8'h3C, 1'b0, 1'b0); add_level(1'b0, 20);
    add_level(1'b1, 4); add_frame(8'h5A, 1'b1, 1'b0); add_level(1'b1, 4);
    run();
    for (int i = 0; i < o_v.size(); i++) begin
      vectors++;
      if ({o_v[i], o_e[i], o_b[i], o_d[i]} !== {e_v[i], e_e[i], e_b[i], e_d[i]}) begin
        miscompares++;
        $display("FAIL frame_err edge %0d: got v=%b e=%b b=%b d=%h, want v=%b e=%b b=%b d=%h",
                 i, o_v[i], o_e[i], o_b[i], o_d[i], e_v[i], e_e[i], e_b[i], e_d[i]);
      end
    end
    vectors++;
    if (o_e[2+LAT] !== 1'b1 || o_v[2+LAT] !== 1'b0 || o_d[2+LAT] !== 8'hA5 ||
        o_b[61] !== 1'b1 || o_b[62] !== 1'b0 || o_v[66+LAT] !== 1'b1 || o_d[66+LAT] !== 8'h5A) begin
      miscompares++;
      $display("FAIL frame_err_points: got e=%b v=%b d=%h b61=%b b62=%b v2=%b d2=%h, want 1 0 a5 1 0 1 5a",
               o_e[2+LAT], o_v[2+LAT], o_d[2+LAT], o_b[61], o_b[62], o_v[66+LAT], o_d[66+LAT]);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] words[3] = '{8'h01, 8'hFF, 8'h80};
    lq.delete(); rq.delete();
    add_level(1'b1, 2);
    for (int f = 0; f < 3; f++) add_frame(words[f], 1'b1, 1'b0);
    add_level(1'b1, 4);
    run();
    for (int i = 0; i < o_v.size(); i++) begin
      vectors++;
      if ({o_v[i], o_e[i], o_b[i], o_d[i]} !== {e_v[i], e_e[i], e_b[i], e_d[i]}) begin
        miscompares++;
        $display("FAIL back_to_back edge %0d: got v=%b e=%b b=%b d=%h, want v=%b e=%b b=%b d=%h",
                 i, o_v[i], o_e[i], o_b[i], o_d[i], e_v[i], e_e[i], e_b[i], e_d[i]);
      end
    end
    for (int f = 0; f < 3; f++) begin
      vectors++;
      if (o_v[2+LAT+40*f] !== 1'b1 || o_d[2+LAT+40*f] !== words[f]) begin
        miscompares++;
        $display("FAIL back_to_back_word%0d: got v=%b d=%h, want v=1 d=%h",
                 f, o_v[2+LAT+40*f], o_d[2+LAT+40*f], words[f]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int nv;
    lq.delete(); rq.delete();
    add_level(1'b1, 2); add_level(1'b0, B);
    add_level(1'b1, 3 * B); add_level(1'b0, B);   // bits 0..3 of 0x77
    add_level(1'b1, 2);                           // first half of bit 4
    lq.push_back(1'b1); rq.push_back(1'b1);       // one reset edge (index 24)
    add_level(1'b1, 4); add_frame(8'h12, 1'b1, 1'b0); add_level(1'b1, 4);
    run();
    for (int i = 0; i < o_v.size(); i++) begin
      vectors++;
      if ({o_v[i], o_e[i], o_b[i], o_d[i]} !== {e_v[i], e_e[i], e_b[i], e_d[i]}) begin
        miscompares++;
        $display("FAIL reset_mid edge %0d: got v=%b e=%b b=%b d=%h, want v=%b e=%b b=%b d=%h",
                 i, o_v[i], o_e[i], o_b[i], o_d[i], e_v[i], e_e[i], e_b[i], e_d[i]);
      end
    end
    nv = 0;
    for (int i = 0; i < 29; i++) if (o_v[i] === 1'b1) nv++;
    vectors++;
    if (nv != 0 || o_d[24] !== 8'h00 || o_b[24] !== 1'b0 || o_v[29+LAT] !== 1'b1 || o_d[29+LAT] !== 8'h12) begin
      miscompares++;
      $display("FAIL reset_mid_points: got strobes=%0d d=%h b=%b v=%b d2=%h, want 0 00 0 1 12",
               nv, o_d[24], o_b[24], o_v[29+LAT], o_d[29+LAT]);
    end
  endtask

  task automatic test_random();
    lq.delete(); rq.delete();
    add_level(1'b1, 2);
    for (int f = 0; f < 10; f++) begin
      case ($urandom_range(0, 5))
        0: begin add_level(1'b0, 1); add_level(1'b1, 2 + $urandom_range(0, 3)); end
        1: begin
          add_frame(W'($urandom), 1'b0, $urandom_range(0, 1) != 0);
          add_level(1'b0, $urandom_range(0, 10));
          add_level(1'b1, 1 + $urandom_range(0, 3));
        end
        default: begin
          add_frame(W'($urandom), 1'b1, $urandom_range(0, 1) != 0);
          add_level(1'b1, $urandom_range(0, 3));
        end
      endcase
    end
    add_level(1'b1, 4);
    run();
    for (int i = 0; i < o_v.size(); i++) begin
      vectors++;
      if ({o_v[i], o_e[i], o_b[i], o_d[i]} !== {e_v[i], e_e[i], e_b[i], e_d[i]}) begin
        miscompares++;
        $display("FAIL random edge %0d: got v=%b e=%b b=%b d=%h, want v=%b e=%b b=%b d=%h",
                 i, o_v[i], o_e[i], o_b[i], o_d[i], e_v[i], e_e[i], e_b[i], e_d[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_mid();
    for (int r = 0; r < 4; r++) test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
